spi_param_decoder: RTL

Frame decoder between the SPI byte receiver and DDS_output, in the clk domain. It assembles command frames from received bytes, validates them with an XOR checksum, and writes them into shadow registers. A commit command copies the shadow registers atomically to freq_reg, wave_reg and amp_reg, and pulses param_ok so the DDS reloads its parameters.

---
 rtl/dds_cfg_pkg.sv | 38 +++
 rtl/spi_param_decoder.sv | 110 +++++++++++
 2 files changed

// File: rtl/dds_cfg_pkg.sv
// Shared DDS configuration definitions: command codes, payload lengths,
// decoder FSM states and parameter register widths.
package dds_cfg_pkg;
  localparam int FREQ_W = 24;
  localparam int WAVE_W = 8;
  localparam int AMP_W  = 16;

  localparam logic [7:0] CMD_FREQ   = 8'h01;
  localparam logic [7:0] CMD_WAVE   = 8'h02;
  localparam logic [7:0] CMD_AMP    = 8'h03;
  localparam logic [7:0] CMD_COMMIT = 8'h0F;

  localparam logic [1:0] LEN_FREQ   = 2'd3;
  localparam logic [1:0] LEN_WAVE   = 2'd1;
  localparam logic [1:0] LEN_AMP    = 2'd2;
  localparam logic [1:0] LEN_COMMIT = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_PAYLOAD, ST_CHECK, ST_APPLY, ST_DISCARD
  } dec_state_t;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_FREQ) || (c == CMD_WAVE) || (c == CMD_AMP) || (c == CMD_COMMIT);
  endfunction

  function automatic logic [1:0] cmd_len(input logic [7:0] c);
    case (c)
      CMD_FREQ: return LEN_FREQ;
      CMD_WAVE: return LEN_WAVE;
      CMD_AMP:  return LEN_AMP;
      default:  return LEN_COMMIT;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/spi_param_decoder.sv
// Assembles SPI command frames into shadow registers; COMMIT copies shadows
// to the DDS parameter outputs in one cycle so the DDS never sees a mix.
module spi_param_decoder
  import dds_cfg_pkg::*;
#(
  parameter logic [FREQ_W-1:0] FREQ_RST     = 24'h000100,
  parameter logic [WAVE_W-1:0] WAVE_RST     = 8'h00,
  parameter logic [AMP_W-1:0]  AMP_RST      = 16'hFFFF,
  parameter bit                USE_CHECKSUM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [FREQ_W-1:0] freq_reg,
  output logic [WAVE_W-1:0] wave_reg,
  output logic [AMP_W-1:0]  amp_reg,
  output logic              param_ok,
  output logic [7:0]        tx_byte,
  output logic [7:0]        err_cnt
);
  dec_state_t        state;
  logic [7:0]        cmd, chk;
  logic [1:0]        cnt;
  logic [FREQ_W-1:0] shift;
  logic [FREQ_W-1:0] shadow_freq;
  logic [WAVE_W-1:0] shadow_wave;
  logic [AMP_W-1:0]  shadow_amp;
  logic              dirty;
  logic [3:0]        last_cmd;

  localparam dec_state_t ST_AFTER_PAYLOAD = USE_CHECKSUM ? ST_CHECK : ST_APPLY;

  assign tx_byte = {dirty, err_cnt != 8'h00, 2'b00, last_cmd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd         <= 8'h00;
      chk         <= 8'h00;
      cnt         <= 2'd0;
      shift       <= '0;
      shadow_freq <= FREQ_RST;
      shadow_wave <= WAVE_RST;
      shadow_amp  <= AMP_RST;
      freq_reg    <= FREQ_RST;
      wave_reg    <= WAVE_RST;
      amp_reg     <= AMP_RST;
      param_ok    <= 1'b0;
      dirty       <= 1'b0;
      last_cmd    <= 4'h0;
      err_cnt     <= 8'h00;
    end else begin
      param_ok <= 1'b0;
      // APPLY completes even if the master deselects in the same cycle
      if (state == ST_APPLY) begin
        case (cmd)
          CMD_FREQ: begin shadow_freq <= shift;                 dirty <= 1'b1; end
          CMD_WAVE: begin shadow_wave <= shift[WAVE_W-1:0];     dirty <= 1'b1; end
          CMD_AMP:  begin shadow_amp  <= shift[AMP_W-1:0];      dirty <= 1'b1; end
          default: begin
            freq_reg <= shadow_freq;
            wave_reg <= shadow_wave;
            amp_reg  <= shadow_amp;
            dirty    <= 1'b0;
            param_ok <= 1'b1;
          end
        endcase
        last_cmd <= cmd[3:0];
        state    <= ss_active ? ST_DISCARD : ST_IDLE;
      end else if (!ss_active) begin
        // deselect beats any byte strobe in the same cycle
        if (state == ST_PAYLOAD || state == ST_CHECK) err_cnt <= sat_inc(err_cnt);
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_CMD;
          ST_CMD: if (rx_valid) begin
            if (cmd_known(rx_byte)) begin
              cmd   <= rx_byte;
              cnt   <= cmd_len(rx_byte);
              shift <= '0;
              chk   <= rx_byte;
              state <= (cmd_len(rx_byte) != 2'd0) ? ST_PAYLOAD : ST_AFTER_PAYLOAD;
            end else begin
              err_cnt <= sat_inc(err_cnt);
              state   <= ST_DISCARD;
            end
          end
          ST_PAYLOAD: if (rx_valid) begin
            shift <= {shift[FREQ_W-9:0], rx_byte};
            chk   <= chk ^ rx_byte;
            cnt   <= cnt - 2'd1;
            if (cnt == 2'd1) state <= ST_AFTER_PAYLOAD;
          end
          ST_CHECK: if (rx_valid) begin
            if (rx_byte == chk) state <= ST_APPLY;
            else begin
              err_cnt <= sat_inc(err_cnt);
              state   <= ST_DISCARD;
            end
          end
          ST_DISCARD: state <= ST_DISCARD;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
